// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Stall, flush and forwarding sequencer for a 5-stage pipeline,
//               with start-up fill, data-memory wait/timeout and perf counters.
// Revision    : 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 16,
    parameter int INIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic             ID_use_rs1,
    input  logic             ID_use_rs2,
    input  logic             ID_is_branch,
    input  logic             ID_redirect,
    input  logic [4:0]       EX_rs1,
    input  logic [4:0]       EX_rs2,
    input  logic [4:0]       EX_rd,
    input  logic             EX_RegWrite,
    input  logic             EX_MemRead,
    input  logic [4:0]       MEM_rd,
    input  logic             MEM_RegWrite,
    input  logic             MEM_MemRead,
    input  logic [4:0]       WB_rd,
    input  logic             WB_RegWrite,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             PC_we,
    output logic             IF_ID_we,
    output logic             IF_ID_flush,
    output logic             ID_EX_we,
    output logic             ID_EX_flush,
    output logic             EX_MEM_we,
    output logic             EX_MEM_flush,
    output logic             MEM_WB_we,
    output logic             MEM_WB_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             fwd_id_a,
    output logic             fwd_id_b,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [1:0] c_INIT     = 2'd0;
    localparam logic [1:0] c_RUN      = 2'd1;
    localparam logic [1:0] c_MEM_WAIT = 2'd2;
    localparam logic [1:0] c_ERROR    = 2'd3;

    localparam logic [INIT_W-1:0] c_INIT_LAST = INIT_W'(INIT_CYCLES - 1);
    localparam logic [WAIT_W-1:0] c_WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [INIT_W-1:0] r_init_cnt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_inc;
    logic              r_mem_err;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic w_active;
    logic w_freeze;
    logic w_timeout;
    logic w_id_uses_ex;
    logic w_id_uses_mem;
    logic w_load_use;
    logic w_br_hazard;
    logic w_stall;
    logic w_redirect;
    logic w_mem_fwd_ok;
    logic w_wb_fwd_ok;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    assign w_active = (r_state == c_RUN) || (r_state == c_MEM_WAIT);

    // Entering the wait from RUN already freezes the pipe in that same cycle.
    always_comb begin
        w_freeze = 1'b0;
        if (r_state == c_RUN) begin
            w_freeze = mem_req && !mem_ready;
        end else if (r_state == c_MEM_WAIT) begin
            w_freeze = !mem_ready;
        end
    end

    // r_wait_cnt is always zero in RUN, so this yields 1 on the first frozen cycle.
    assign w_wait_inc = r_wait_cnt + WAIT_W'(1);
    assign w_timeout  = w_freeze && (w_wait_inc == c_WAIT_MAX);

    assign w_id_uses_ex  = (ID_use_rs1 && (ID_rs1 == EX_rd)) ||
                           (ID_use_rs2 && (ID_rs2 == EX_rd));
    assign w_id_uses_mem = (ID_use_rs1 && (ID_rs1 == MEM_rd)) ||
                           (ID_use_rs2 && (ID_rs2 == MEM_rd));

    assign w_load_use  = EX_MemRead && (EX_rd != 5'd0) && w_id_uses_ex;
    assign w_br_hazard = ID_is_branch &&
                         ((EX_RegWrite && (EX_rd != 5'd0) && w_id_uses_ex) ||
                          (MEM_MemRead && (MEM_rd != 5'd0) && w_id_uses_mem));
    assign w_stall     = w_load_use || w_br_hazard;
    assign w_redirect  = w_active && !w_freeze && !w_stall && ID_redirect;

    // A load in MEM has no data yet; WB forwards it on the following cycle.
    assign w_mem_fwd_ok = MEM_RegWrite && !MEM_MemRead && (MEM_rd != 5'd0);
    assign w_wb_fwd_ok  = WB_RegWrite && (WB_rd != 5'd0);

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_INIT: begin
                if (r_init_cnt == c_INIT_LAST) begin
                    w_state_nxt = c_RUN;
                end
            end
            c_RUN, c_MEM_WAIT: begin
                if (w_timeout) begin
                    w_state_nxt = c_ERROR;
                end else if (w_freeze) begin
                    w_state_nxt = c_MEM_WAIT;
                end else begin
                    w_state_nxt = c_RUN;
                end
            end
            c_ERROR: w_state_nxt = c_ERROR;
            default: w_state_nxt = c_INIT;
        endcase
    end

    // ------------------------------------------------------------------
    // Control outputs
    // ------------------------------------------------------------------
    always_comb begin
        PC_we        = 1'b0;
        IF_ID_we     = 1'b0;
        IF_ID_flush  = 1'b0;
        ID_EX_we     = 1'b0;
        ID_EX_flush  = 1'b0;
        EX_MEM_we    = 1'b0;
        EX_MEM_flush = 1'b0;
        MEM_WB_we    = 1'b0;
        MEM_WB_flush = 1'b0;
        fwd_a        = 2'b00;
        fwd_b        = 2'b00;
        fwd_id_a     = 1'b0;
        fwd_id_b     = 1'b0;
        case (r_state)
            c_INIT: begin
                IF_ID_flush  = 1'b1;
                ID_EX_flush  = 1'b1;
                EX_MEM_flush = 1'b1;
                MEM_WB_flush = 1'b1;
            end
            c_RUN, c_MEM_WAIT: begin
                if (w_mem_fwd_ok && (MEM_rd == EX_rs1)) begin
                    fwd_a = 2'b10;
                end else if (w_wb_fwd_ok && (WB_rd == EX_rs1)) begin
                    fwd_a = 2'b01;
                end
                if (w_mem_fwd_ok && (MEM_rd == EX_rs2)) begin
                    fwd_b = 2'b10;
                end else if (w_wb_fwd_ok && (WB_rd == EX_rs2)) begin
                    fwd_b = 2'b01;
                end
                fwd_id_a = w_mem_fwd_ok && (MEM_rd == ID_rs1);
                fwd_id_b = w_mem_fwd_ok && (MEM_rd == ID_rs2);

                if (w_freeze) begin
                    // Upstream holds; MEM/WB takes a bubble.
                    MEM_WB_we    = 1'b1;
                    MEM_WB_flush = 1'b1;
                end else begin
                    PC_we     = 1'b1;
                    IF_ID_we  = 1'b1;
                    ID_EX_we  = 1'b1;
                    EX_MEM_we = 1'b1;
                    MEM_WB_we = 1'b1;
                    if (w_stall) begin
                        PC_we       = 1'b0;
                        IF_ID_we    = 1'b0;
                        ID_EX_flush = 1'b1;
                    end else if (ID_redirect) begin
                        IF_ID_flush = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // State, counters and sticky error
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_INIT;
            r_init_cnt  <= '0;
            r_wait_cnt  <= '0;
            r_mem_err   <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == c_INIT) && (r_init_cnt != c_INIT_LAST)) begin
                r_init_cnt <= r_init_cnt + INIT_W'(1);
            end
            if (w_active) begin
                r_wait_cnt <= w_freeze ? w_wait_inc : '0;
                if (w_timeout) begin
                    r_mem_err <= 1'b1;
                end
                if (!PC_we && (r_stall_cnt != {CNT_W{1'b1}})) begin
                    r_stall_cnt <= r_stall_cnt + CNT_W'(1);
                end
                if (w_redirect && (r_flush_cnt != {CNT_W{1'b1}})) begin
                    r_flush_cnt <= r_flush_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign mem_err   = r_mem_err;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Directed scenarios plus randomized traffic against a
//               cycle-level behavioural model of the hazard controller.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 6;
    localparam int INIT_CYCLES = 2;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       ID_rs1, ID_rs2, EX_rs1, EX_rs2, EX_rd, MEM_rd, WB_rd;
    logic             ID_use_rs1, ID_use_rs2, ID_is_branch, ID_redirect;
    logic             EX_RegWrite, EX_MemRead, MEM_RegWrite, MEM_MemRead, WB_RegWrite;
    logic             mem_req, mem_ready;
    logic             PC_we, IF_ID_we, IF_ID_flush, ID_EX_we, ID_EX_flush;
    logic             EX_MEM_we, EX_MEM_flush, MEM_WB_we, MEM_WB_flush;
    logic [1:0]       fwd_a, fwd_b;
    logic             fwd_id_a, fwd_id_b, mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    pipeline_hazard_ctrl #(
        .CNT_W       (CNT_W),
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .INIT_CYCLES (INIT_CYCLES)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .ID_rs1       (ID_rs1),
        .ID_rs2       (ID_rs2),
        .ID_use_rs1   (ID_use_rs1),
        .ID_use_rs2   (ID_use_rs2),
        .ID_is_branch (ID_is_branch),
        .ID_redirect  (ID_redirect),
        .EX_rs1       (EX_rs1),
        .EX_rs2       (EX_rs2),
        .EX_rd        (EX_rd),
        .EX_RegWrite  (EX_RegWrite),
        .EX_MemRead   (EX_MemRead),
        .MEM_rd       (MEM_rd),
        .MEM_RegWrite (MEM_RegWrite),
        .MEM_MemRead  (MEM_MemRead),
        .WB_rd        (WB_rd),
        .WB_RegWrite  (WB_RegWrite),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .PC_we        (PC_we),
        .IF_ID_we     (IF_ID_we),
        .IF_ID_flush  (IF_ID_flush),
        .ID_EX_we     (ID_EX_we),
        .ID_EX_flush  (ID_EX_flush),
        .EX_MEM_we    (EX_MEM_we),
        .EX_MEM_flush (EX_MEM_flush),
        .MEM_WB_we    (MEM_WB_we),
        .MEM_WB_flush (MEM_WB_flush),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .fwd_id_a     (fwd_id_a),
        .fwd_id_b     (fwd_id_b),
        .mem_err      (mem_err),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: cycles since reset release, consecutive frozen cycles,
    // sticky error and the two counters as plain integers.
    int m_since, m_freeze, m_stalls, m_flushes;
    bit m_err;

    // Expected outputs for the current cycle.
    bit       e_pc, e_ifw, e_iff, e_idw, e_idf, e_exw, e_exf, e_mww, e_mwf;
    bit [1:0] e_fa, e_fb;
    bit       e_fia, e_fib, e_frozen, e_redir;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit id_reads(input logic [4:0] r);
        return (ID_use_rs1 && ID_rs1 == r) || (ID_use_rs2 && ID_rs2 == r);
    endfunction

    function automatic bit [1:0] ex_src(input logic [4:0] rs);
        if (MEM_RegWrite && !MEM_MemRead && MEM_rd != 0 && MEM_rd == rs) return 2'b10;
        if (WB_RegWrite && WB_rd != 0 && WB_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic predict();
        bit hazard;
        if (!reset) begin
            m_since = 0; m_freeze = 0; m_err = 0; m_stalls = 0; m_flushes = 0;
        end
        {e_pc, e_ifw, e_iff, e_idw, e_idf, e_exw, e_exf, e_mww, e_mwf} = '0;
        {e_fa, e_fb, e_fia, e_fib, e_frozen, e_redir} = '0;
        if (!reset || m_since < INIT_CYCLES) begin
            {e_iff, e_idf, e_exf, e_mwf} = 4'b1111;
        end else if (!m_err) begin
            e_fa  = ex_src(EX_rs1);
            e_fb  = ex_src(EX_rs2);
            e_fia = MEM_RegWrite && !MEM_MemRead && MEM_rd != 0 && MEM_rd == ID_rs1;
            e_fib = MEM_RegWrite && !MEM_MemRead && MEM_rd != 0 && MEM_rd == ID_rs2;
            e_frozen = (m_freeze == 0) ? (mem_req && !mem_ready) : !mem_ready;
            if (e_frozen) begin
                e_mww = 1; e_mwf = 1;
            end else begin
                hazard = (EX_MemRead && EX_rd != 0 && id_reads(EX_rd)) ||
                         (ID_is_branch && ((EX_RegWrite && EX_rd != 0 && id_reads(EX_rd)) ||
                                           (MEM_MemRead && MEM_rd != 0 && id_reads(MEM_rd))));
                {e_pc, e_ifw, e_idw, e_exw, e_mww} = 5'b11111;
                if (hazard) begin
                    e_pc = 0; e_ifw = 0; e_idf = 1;
                end else if (ID_redirect) begin
                    e_iff = 1; e_redir = 1;
                end
            end
        end
    endtask

    task automatic update_model();
        if (!reset) return;
        if (m_since < INIT_CYCLES) begin
            m_since++;
        end else if (!m_err) begin
            if (e_frozen) begin
                m_freeze++;
                if (m_freeze >= MEM_TIMEOUT) m_err = 1;
            end else begin
                m_freeze = 0;
            end
            if (!e_pc && m_stalls < CNT_MAX) m_stalls++;
            if (e_redir && m_flushes < CNT_MAX) m_flushes++;
        end
    endtask

    // Inputs are set at a falling edge; check 1 time unit later, then clock.
    task automatic step();
        #1;
        predict();
        check_eq("ctrl", {PC_we, IF_ID_we, IF_ID_flush, ID_EX_we, ID_EX_flush,
                          EX_MEM_we, EX_MEM_flush, MEM_WB_we, MEM_WB_flush},
                 {e_pc, e_ifw, e_iff, e_idw, e_idf, e_exw, e_exf, e_mww, e_mwf});
        check_eq("fwd_a", fwd_a, e_fa);
        check_eq("fwd_b", fwd_b, e_fb);
        check_eq("fwd_id", {fwd_id_a, fwd_id_b}, {e_fia, e_fib});
        check_eq("mem_err", mem_err, m_err);
        check_eq("stall_cnt", stall_cnt, m_stalls);
        check_eq("flush_cnt", flush_cnt, m_flushes);
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    task automatic idle();
        {ID_rs1, ID_rs2, EX_rs1, EX_rs2, EX_rd, MEM_rd, WB_rd} = '0;
        {ID_use_rs1, ID_use_rs2, ID_is_branch, ID_redirect} = '0;
        {EX_RegWrite, EX_MemRead, MEM_RegWrite, MEM_MemRead, WB_RegWrite} = '0;
        mem_req = 0; mem_ready = 0;
    endtask

    task automatic do_reset(input int n);
        idle();
        reset = 0;
        repeat (n) step();
        reset = 1;
        repeat (INIT_CYCLES) step();
    endtask

    task automatic rand_inputs(input int rdy_bias);
        ID_rs1 = 5'($urandom_range(0, 3));  ID_rs2 = 5'($urandom_range(0, 3));
        EX_rs1 = 5'($urandom_range(0, 3));  EX_rs2 = 5'($urandom_range(0, 3));
        EX_rd  = 5'($urandom_range(0, 3));  MEM_rd = 5'($urandom_range(0, 3));
        WB_rd  = 5'($urandom_range(0, 3));
        ID_use_rs1   = 1'($urandom_range(0, 1)); ID_use_rs2  = 1'($urandom_range(0, 1));
        ID_is_branch = ($urandom_range(0, 3) == 0);
        ID_redirect  = ($urandom_range(0, 2) == 0);
        EX_RegWrite  = 1'($urandom_range(0, 1)); EX_MemRead  = ($urandom_range(0, 3) == 0);
        MEM_RegWrite = 1'($urandom_range(0, 1)); MEM_MemRead = ($urandom_range(0, 3) == 0);
        WB_RegWrite  = 1'($urandom_range(0, 1));
        mem_req   = ($urandom_range(0, 3) == 0);
        mem_ready = ($urandom_range(0, 7) < rdy_bias);
    endtask

    initial begin
        int rdy_bias;
        idle();
        reset = 0;
        @(negedge clk);

        // Reset, then INIT_CYCLES of forced bubbles before RUN.
        repeat (3) step();
        reset = 1;
        #1 check_eq("t1_init_pc0", PC_we, 0);
        step();
        #1 check_eq("t1_init_flush", IF_ID_flush, 1);
        step();
        #1 check_eq("t1_run_pc", PC_we, 1);
        step();

        // Load-use: lw x5 in EX, add x6,x5,x1 in ID.
        EX_MemRead = 1; EX_RegWrite = 1; EX_rd = 5;
        ID_rs1 = 5; ID_use_rs1 = 1; ID_rs2 = 1; ID_use_rs2 = 1;
        #1 check_eq("t2_stall_pc", PC_we, 0);
        check_eq("t2_idex_flush", ID_EX_flush, 1);
        step();
        idle();
        WB_RegWrite = 1; WB_rd = 5; EX_rs1 = 5; EX_rs2 = 1;
        #1 check_eq("t2_fwd_wb", fwd_a, 2'b01);
        check_eq("t2_stall_cnt", stall_cnt, 1);
        step();

        // Branch operand from ALU op in EX, then redirect with MEM forward.
        idle();
        EX_RegWrite = 1; EX_rd = 7;
        ID_is_branch = 1; ID_rs1 = 7; ID_use_rs1 = 1; ID_use_rs2 = 1; ID_redirect = 1;
        #1 check_eq("t3_stall_pc", PC_we, 0);
        check_eq("t3_no_redirect", IF_ID_flush, 0);
        step();
        EX_RegWrite = 0; EX_rd = 0; MEM_RegWrite = 1; MEM_rd = 7;
        #1 check_eq("t3_fwd_id", fwd_id_a, 1);
        check_eq("t3_ifid_flush", IF_ID_flush, 1);
        step();
        idle();
        #1 check_eq("t3_flush_cnt", flush_cnt, 1);
        step();

        // Three wait cycles, then ready.
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1 check_eq("t4_freeze_pc", PC_we, 0);
            check_eq("t4_wb_bubble", MEM_WB_flush, 1);
            step();
        end
        mem_ready = 1;
        #1 check_eq("t4_resume_pc", PC_we, 1);
        step();
        idle();
        step();

        // Timeout into ERROR; outputs stay frozen whatever the inputs do.
        mem_req = 1; mem_ready = 0;
        repeat (MEM_TIMEOUT) step();
        mem_ready = 1; ID_redirect = 1;
        #1 check_eq("t5_mem_err", mem_err, 1);
        check_eq("t5_err_ctrl", {PC_we, IF_ID_flush, MEM_WB_we, MEM_WB_flush}, 4'b0000);
        repeat (3) step();

        // Reset in the middle of a memory wait.
        do_reset(1);
        mem_req = 1; mem_ready = 0;
        repeat (2) step();
        reset = 0;
        #1 check_eq("t5_rst_err", mem_err, 0);
        check_eq("t5_rst_flush", {PC_we, IF_ID_flush}, 2'b01);
        step();
        do_reset(1);

        // Forwarding priority and x0.
        EX_RegWrite = 1; MEM_RegWrite = 1; WB_RegWrite = 1;
        EX_rd = 3; MEM_rd = 3; WB_rd = 3; EX_rs1 = 3;
        #1 check_eq("t6_fwd_mem", fwd_a, 2'b10);
        step();
        EX_rd = 0; MEM_rd = 0; WB_rd = 0; EX_rs1 = 0;
        #1 check_eq("t6_fwd_x0", fwd_a, 2'b00);
        step();

        // Stall counter saturates.
        do_reset(1);
        EX_MemRead = 1; EX_rd = 2; ID_rs1 = 2; ID_use_rs1 = 1;
        repeat (CNT_MAX + 4) step();
        idle();
        #1 check_eq("sat_stall_cnt", stall_cnt, CNT_MAX);
        step();

        // Randomized traffic with occasional resets.
        rdy_bias = 4;
        for (int c = 0; c < 4000; c++) begin
            if (c % 64 == 0) rdy_bias = $urandom_range(1, 7);
            rand_inputs(rdy_bias);
            reset = (m_err ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 149) == 0)) ? 1'b0 : 1'b1;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
